iq_usb_packetizer: RTL and testbench
====================================

IQ_USB_PACKETIZER -- requirements
Module: iq_usb_packetizer

Interface
REQ-001 The parameter list SHALL be: WORDS_PER_PKT, default 256, 16-bit words per USB bulk packet (512 bytes).
REQ-002 The parameter list SHALL also include FLUSH_TIMEOUT, default 4096, the number of idle clk cycles before a partial packet is committed.
REQ-003 The port list SHALL be, in order (name, direction, width, meaning):
- clk, in, 1: IFCLK domain clock; the single clock of the block.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: streaming enable.
- i_data, in, 32: head of the I FIFO (show-ahead).
- q_data, in, 32: head of the Q FIFO (show-ahead).
- i_empty, in, 1: I FIFO empty.
- q_empty, in, 1: Q FIFO empty.
- iq_rdreq, out, 1: pops both FIFOs together.
- fx2_full_n, in, 1: FX2 EP6 full flag, active-low.
- fd, out, 16: FX2 data bus.
- slwr_n, out, 1: FX2 write strobe, active-low.
- pktend_n, out, 1: FX2 packet-end strobe, active-low.
- fifo_adr, out, 2: FX2 endpoint select.
- pkt_count, out, 16: count of committed packets, wrapping.

Function
REQ-004 fifo_adr SHALL be constant 2'b10 (EP6).
REQ-005 fd, slwr_n and pktend_n SHALL be registered outputs.
REQ-006 The state machine SHALL have the states IDLE, ILO, IHI, QLO, QHI and PKTEND.
REQ-007 In IDLE, when enable=1, i_empty=0, q_empty=0 and fx2_full_n=1, the block SHALL:
- assert iq_rdreq for exactly one cycle;
- capture i_data and q_data into hold registers on that same edge;
- go to ILO.
REQ-008 In each of ILO, IHI, QLO and QHI, when fx2_full_n=1 the block SHALL drive the next word with slwr_n=0 for one cycle and advance to the next state.
- Word order: I[15:0], I[31:16], Q[15:0], Q[31:16].
- QHI returns to IDLE.
REQ-009 When fx2_full_n=0 in a word state, the block SHALL:
- hold slwr_n=1, the current state and the current fd;
- resume with the same word once fx2_full_n=1.
- No word is dropped or duplicated.
REQ-010 iq_rdreq SHALL never assert outside IDLE, and SHALL never assert while either FIFO is empty.
REQ-011 A 4-word group SHALL always complete once started, even if enable falls mid-group; new groups start only with enable=1.
REQ-012 word_cnt SHALL increment on each slwr_n=0 cycle.
- On reaching WORDS_PER_PKT it SHALL wrap to 0 and pkt_count SHALL increment (the FX2 AUTOIN commits the packet).
REQ-013 idle_cnt SHALL:
- increment in IDLE while word_cnt!=0 and no pop occurs;
- clear on any pop or whenever word_cnt=0.
REQ-014 When idle_cnt reaches FLUSH_TIMEOUT, the block SHALL go to PKTEND.
REQ-015 In PKTEND, when fx2_full_n=1 the block SHALL:
- drive pktend_n=0 for exactly one cycle;
- clear word_cnt and idle_cnt;
- increment pkt_count;
- return to IDLE.
REQ-016 If a pop condition and the timeout occur in the same cycle, the pop SHALL win and idle_cnt SHALL clear.
REQ-017 pktend_n and slwr_n SHALL never be low in the same cycle.
REQ-018 Latency SHALL be: FIFO pop edge to first slwr_n=0 edge is exactly 1 cycle with fx2_full_n=1; a group takes 5 cycles including the pop cycle.

Reset
REQ-019 On reset, the block SHALL set:
- state=IDLE;
- slwr_n=1, pktend_n=1, iq_rdreq=0;
- fd=16'h0000;
- word_cnt=0, idle_cnt=0, pkt_count=0;
- hold registers=0.
REQ-020 Reset asserted mid-group SHALL abandon the group; the next write after reset SHALL start at ILO of a fresh pop.

Structure
REQ-021 A shared package SHALL hold:
- the EP6 address constant 2'b10;
- the default values of WORDS_PER_PKT and FLUSH_TIMEOUT;
- the state encoding.
REQ-022 The block SHALL be a single module with no sub-modules; the FIFOs stay outside.

Verification
REQ-023 Bench scenario, single group: I=32'h89ABCDEF, Q=32'h01234567, FX2 never full -> fd sequence CDEF, 89AB, 4567, 0123 on 4 consecutive slwr_n=0 cycles, and one iq_rdreq pulse.
REQ-024 Bench scenario, full stall: fx2_full_n=0 for 3 cycles during IHI -> slwr_n=1 for 3 cycles, then 89AB is written once and the sequence continues intact.
REQ-025 Bench scenario, packet wrap: 64 consecutive groups -> 256 writes, pkt_count=1, word_cnt=0, and no pktend_n pulse.
REQ-026 Bench scenario, timeout flush: 3 groups, then the FIFOs stay empty -> exactly one pktend_n=0 pulse FLUSH_TIMEOUT cycles after the last pop, and pkt_count=1.
REQ-027 Bench scenario, enable drop: enable drops during QLO -> QLO and QHI are still written, and no further iq_rdreq occurs.
REQ-028 Bench scenario, reset mid-group: reset in IHI -> the next cycle shows all outputs at reset values, and the following group starts with ILO.

Source files
------------

// File: rtl/iq_usb_packetizer_pkg.sv
// Shared constants, state encoding and word-selection helpers for the
// IQ-to-FX2 slave-FIFO packetizer.
package iq_usb_packetizer_pkg;

    // FX2 endpoint select for EP6 (IN endpoint fed by this block)
    localparam logic [1:0] EP6_ADR = 2'b10;

    // 512-byte bulk packet = 256 16-bit words
    localparam int DEF_WORDS_PER_PKT = 256;
    // Idle clk cycles before a partial packet is pushed out with PKTEND
    localparam int DEF_FLUSH_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ILO,
        IHI,
        QLO,
        QHI,
        PKTEND
    } state_e;

    // Word driven onto fd while in a given word state
    function automatic logic [15:0] word_sel(input state_e s,
                                             input logic [31:0] i_w,
                                             input logic [31:0] q_w);
        case (s)
            ILO:     return i_w[15:0];
            IHI:     return i_w[31:16];
            QLO:     return q_w[15:0];
            default: return q_w[31:16];
        endcase
    endfunction

    // Successor of a word state; the last word hands back to IDLE
    function automatic state_e word_next(input state_e s);
        case (s)
            ILO:     return IHI;
            IHI:     return QLO;
            QLO:     return QHI;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/iq_usb_packetizer.sv
// Pops paired I/Q samples from two show-ahead FIFOs and streams them to the
// FX2 slave FIFO (EP6) as four 16-bit words per pair. Full packets are
// committed by the FX2 AUTOIN logic; partial packets are flushed with a
// PKTEND strobe after a period of inactivity.
module iq_usb_packetizer
    import iq_usb_packetizer_pkg::*;
#(
    parameter int WORDS_PER_PKT = DEF_WORDS_PER_PKT,
    parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] i_data,
    input  logic [31:0] q_data,
    input  logic        i_empty,
    input  logic        q_empty,
    output logic        iq_rdreq,
    input  logic        fx2_full_n,
    output logic [15:0] fd,
    output logic        slwr_n,
    output logic        pktend_n,
    output logic [1:0]  fifo_adr,
    output logic [15:0] pkt_count
);

    localparam int WC_W = $clog2(WORDS_PER_PKT + 1);
    localparam int IC_W = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WORDS_PER_PKT - 1);
    localparam logic [IC_W-1:0] IC_LIMIT = IC_W'(FLUSH_TIMEOUT);

    state_e          state_q, state_d;
    logic [31:0]     hold_i_q, hold_i_d;
    logic [31:0]     hold_q_q, hold_q_d;
    logic [15:0]     fd_q, fd_d;
    logic            slwr_n_q, slwr_n_d;
    logic            pktend_n_q, pktend_n_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [15:0]     pkt_count_q, pkt_count_d;
    logic            pop;

    // Pop both FIFOs together only from IDLE with data on both sides and room
    // in the FX2; gated by reset so nothing is consumed while held in reset.
    assign pop = (state_q == IDLE) && enable && !i_empty && !q_empty &&
                 fx2_full_n && !reset;

    assign iq_rdreq  = pop;
    assign fifo_adr  = EP6_ADR;
    assign fd        = fd_q;
    assign slwr_n    = slwr_n_q;
    assign pktend_n  = pktend_n_q;
    assign pkt_count = pkt_count_q;

    // Next-state, strobe and counter logic; strobes default to inactive so
    // each write/pktend lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        hold_i_d    = hold_i_q;
        hold_q_d    = hold_q_q;
        fd_d        = fd_q;
        slwr_n_d    = 1'b1;
        pktend_n_d  = 1'b1;
        word_cnt_d  = word_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            IDLE: begin
                // A pop beats the flush timeout when both land together
                if (pop) begin
                    hold_i_d   = i_data;
                    hold_q_d   = q_data;
                    idle_cnt_d = '0;
                    state_d    = ILO;
                end else if (word_cnt_q == '0) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IC_LIMIT) begin
                    state_d = PKTEND;
                end else begin
                    idle_cnt_d = idle_cnt_q + IC_W'(1);
                end
            end
            ILO, IHI, QLO, QHI: begin
                // While the FX2 is full, fd and the state simply hold
                if (fx2_full_n) begin
                    fd_d     = word_sel(state_q, hold_i_q, hold_q_q);
                    slwr_n_d = 1'b0;
                    state_d  = word_next(state_q);
                    if (word_cnt_q == WC_LAST) begin
                        word_cnt_d  = '0;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            PKTEND: begin
                if (fx2_full_n) begin
                    pktend_n_d  = 1'b0;
                    word_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any group in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_i_q    <= '0;
            hold_q_q    <= '0;
            fd_q        <= '0;
            slwr_n_q    <= 1'b1;
            pktend_n_q  <= 1'b1;
            word_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_i_q    <= hold_i_d;
            hold_q_q    <= hold_q_d;
            fd_q        <= fd_d;
            slwr_n_q    <= slwr_n_d;
            pktend_n_q  <= pktend_n_d;
            word_cnt_q  <= word_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_iq_usb_packetizer.sv
// Directed bench for iq_usb_packetizer: table of single groups plus
// hand-written stall, enable-drop, reset, packet-wrap and flush sequences.
module tb_iq_usb_packetizer;

    localparam int WPP = 256;
    localparam int FT  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] i_data = '0;
    logic [31:0] q_data = '0;
    logic        i_empty = 1'b1;
    logic        q_empty = 1'b1;
    logic        iq_rdreq;
    logic        fx2_full_n = 1'b1;
    logic [15:0] fd;
    logic        slwr_n;
    logic        pktend_n;
    logic [1:0]  fifo_adr;
    logic [15:0] pkt_count;

    iq_usb_packetizer #(.WORDS_PER_PKT(WPP), .FLUSH_TIMEOUT(FT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .i_data(i_data), .q_data(q_data), .i_empty(i_empty), .q_empty(q_empty),
        .iq_rdreq(iq_rdreq), .fx2_full_n(fx2_full_n), .fd(fd), .slwr_n(slwr_n),
        .pktend_n(pktend_n), .fifo_adr(fifo_adr), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Edge counter: after posedge n, cyc == n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Show-ahead FIFO model: main process appends, this process pops
    logic [31:0] fi[$];
    logic [31:0] fq[$];
    int rd_ptr = 0;
    initial begin
        logic popped;
        forever begin
            @(negedge clk);
            popped = iq_rdreq;
            @(posedge clk);
            #2;
            if (popped) rd_ptr++;
            if (rd_ptr < fi.size()) begin
                i_data = fi[rd_ptr]; q_data = fq[rd_ptr];
                i_empty = 1'b0; q_empty = 1'b0;
            end else begin
                i_data = '0; q_data = '0;
                i_empty = 1'b1; q_empty = 1'b1;
            end
        end
    end

    // Bus monitor sampled on the falling edge
    logic [15:0] wr_q[$];
    int wr_cyc[$];
    int pe_cnt = 0, pe_cyc = 0, rd_cnt = 0, rd_cyc = 0, rd_bad = 0, both_low = 0;
    initial forever begin
        @(negedge clk);
        if (slwr_n === 1'b0) begin wr_q.push_back(fd); wr_cyc.push_back(cyc); end
        if (pktend_n === 1'b0) begin pe_cnt++; pe_cyc = cyc; end
        if (iq_rdreq === 1'b1) begin
            rd_cnt++; rd_cyc = cyc;
            if (i_empty || q_empty) rd_bad++;
        end
        if (slwr_n === 1'b0 && pktend_n === 1'b0) both_low++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [31:0] iv, input logic [31:0] qv);
        fi.push_back(iv); fq.push_back(qv);
    endtask

    // Wait for the write log to reach n entries, then let stragglers land
    task automatic wait_writes(input string nm, input int n, input int budget);
        int k = 0;
        while (wr_q.size() < n && k < budget) begin tick(1); k++; end
        tick(4);
        chk({nm, "_wr_count"}, wr_q.size(), n);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(1); reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic [15:0] w0, w1, w2, w3;
    } vec_t;

    function automatic logic [15:0] exp_w(input vec_t v, input int j);
        case (j)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return v.w3;
        endcase
    endfunction

    vec_t vecs[4];

    initial begin
        int wb, rb, pb, tgt, bad;
        vec_t sv;

        vecs[0] = '{32'h89ABCDEF, 32'h01234567, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        vecs[1] = '{32'hFFFF0000, 32'h0000FFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 16'h5678, 16'h1234, 16'hDEF0, 16'h9ABC};
        vecs[3] = '{32'h00000001, 32'h80000000, 16'h0001, 16'h0000, 16'h0000, 16'h8000};

        // Reset state, sampled while reset is still high
        tick(2);
        chk("rst_slwr_n", slwr_n, 1);
        chk("rst_pktend_n", pktend_n, 1);
        chk("rst_fd", fd, 0);
        chk("rst_rdreq", iq_rdreq, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("fifo_adr", fifo_adr, 2'b10);
        reset = 1'b0;
        enable = 1'b1;
        tick(2);

        // Table: one group each, FX2 never full
        for (int v = 0; v < 4; v++) begin
            wb = wr_q.size(); rb = rd_cnt;
            push(vecs[v].i, vecs[v].q);
            wait_writes($sformatf("vec%0d", v), wb + 4, 20);
            for (int j = 0; j < 4; j++)
                if (wb + j < wr_q.size())
                    chk($sformatf("vec%0d_w%0d", v, j), wr_q[wb + j], exp_w(vecs[v], j));
            chk($sformatf("vec%0d_rdreq", v), rd_cnt - rb, 1);
            if (wr_q.size() >= wb + 4) begin
                // rdreq seen in cycle c, pop edge c+1, first slwr_n=0 after edge c+2
                chk($sformatf("vec%0d_latency", v), wr_cyc[wb] - rd_cyc, 2);
                chk($sformatf("vec%0d_back2back", v), wr_cyc[wb + 3] - wr_cyc[wb], 3);
            end
        end

        // FX2 full for 3 cycles while in IHI
        sv = vecs[0];
        wb = wr_q.size();
        push(sv.i, sv.q);
        tick(2);               // pop edge -> ILO, then ILO written -> IHI
        fx2_full_n = 1'b0;
        tick(3);
        fx2_full_n = 1'b1;
        wait_writes("stall", wb + 4, 20);
        for (int j = 0; j < 4; j++)
            if (wb + j < wr_q.size())
                chk($sformatf("stall_w%0d", j), wr_q[wb + j], exp_w(sv, j));
        if (wr_q.size() >= wb + 4) begin
            chk("stall_gap", wr_cyc[wb + 1] - wr_cyc[wb], 4);
            chk("stall_tail", wr_cyc[wb + 3] - wr_cyc[wb + 1], 2);
        end

        // Enable drops during QLO with another group already queued
        wb = wr_q.size(); rb = rd_cnt;
        push(32'hAAAA5555, 32'h3333CCCC);
        push(32'h0F0F1E1E, 32'h2D2D3C3C);
        tick(3);               // pop -> ILO -> IHI -> QLO
        enable = 1'b0;
        wait_writes("endrop", wb + 4, 20);
        tick(10);
        chk("endrop_count", wr_q.size(), wb + 4);
        if (wr_q.size() >= wb + 4) begin
            chk("endrop_qlo", wr_q[wb + 2], 16'hCCCC);
            chk("endrop_qhi", wr_q[wb + 3], 16'h3333);
        end
        chk("endrop_rdreq", rd_cnt - rb, 1);
        enable = 1'b1;
        wait_writes("endrop_resume", wb + 8, 20);
        if (wr_q.size() >= wb + 8) chk("endrop_resume_w0", wr_q[wb + 4], 16'h1E1E);

        // Reset while in IHI: group abandoned, next write is ILO of a fresh pop
        push(32'h11112222, 32'h33334444);
        push(32'h55556666, 32'h77778888);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midrst_slwr_n", slwr_n, 1);
        chk("midrst_pktend_n", pktend_n, 1);
        chk("midrst_fd", fd, 0);
        chk("midrst_rdreq", iq_rdreq, 0);
        chk("midrst_pkt_count", pkt_count, 0);
        wb = wr_q.size();
        reset = 1'b0;
        wait_writes("midrst", wb + 4, 20);
        if (wr_q.size() >= wb + 4) begin
            chk("midrst_w0", wr_q[wb], 16'h6666);
            chk("midrst_w3", wr_q[wb + 3], 16'h7777);
        end

        // 64 groups fill exactly one packet: AUTOIN commit, no PKTEND
        do_reset();
        wb = wr_q.size(); pb = pe_cnt;
        for (int k = 0; k < 64; k++) push({16'hA000 + 16'(k), 16'h1000 + 16'(k)},
                                          {16'hC000 + 16'(k), 16'h3000 + 16'(k)});
        wait_writes("wrap", wb + 256, 64 * 5 + 40);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (wb + 4 * k + 3 < wr_q.size())
                if (wr_q[wb + 4*k]     !== 16'h1000 + 16'(k) || wr_q[wb + 4*k + 1] !== 16'hA000 + 16'(k) ||
                    wr_q[wb + 4*k + 2] !== 16'h3000 + 16'(k) || wr_q[wb + 4*k + 3] !== 16'hC000 + 16'(k))
                    bad++;
        chk("wrap_data_errs", bad, 0);
        chk("wrap_pkt_count", pkt_count, 1);
        // word_cnt back at 0 means no flush ever fires
        tick(FT + 20);
        chk("wrap_no_pktend", pe_cnt - pb, 0);

        // Three groups then silence: one PKTEND after the timeout
        do_reset();
        wb = wr_q.size(); pb = pe_cnt;
        for (int k = 0; k < 3; k++) push(32'hBEEF0000 + k, 32'hFACE0000 + k);
        wait_writes("flush", wb + 12, 40);
        tgt = 0;
        while (pe_cnt == pb && tgt < FT + 40) begin tick(1); tgt++; end
        tick(10);
        chk("flush_pulses", pe_cnt - pb, 1);
        // From the pop edge: 4 write edges, FT idle counts, 1 edge into
        // PKTEND, 1 edge registering the strobe
        chk("flush_timing", pe_cyc - (rd_cyc + 1), FT + 6);
        chk("flush_pkt_count", pkt_count, 1);

        // Pop arriving in the very cycle the timeout is reached wins
        do_reset();
        pb = pe_cnt;
        wb = wr_q.size();
        push(32'h01010202, 32'h03030404);
        wait_writes("race_first", wb + 4, 20);
        tgt = rd_cyc + 5 + FT;
        while (cyc < tgt) tick(1);
        push(32'h05050606, 32'h07070808);
        wait_writes("race_second", wb + 8, 20);
        tick(20);
        chk("race_pop_cycle", rd_cyc, tgt);
        chk("race_no_pktend", pe_cnt - pb, 0);
        chk("race_pkt_count", pkt_count, 0);

        // Global invariants
        chk("rdreq_while_empty", rd_bad, 0);
        chk("slwr_pktend_overlap", both_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
